// File: rtl/adder_seq_arbiter_pkg.sv
// Shared definitions for the chunked adder arbiter: chunk width,
// requester count and FSM state encoding.
package adder_seq_arbiter_pkg;

    localparam int unsigned CHUNK_W = 3;
    localparam int unsigned NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/adder_seq_arbiter_if.sv
// Request/grant/result bundle between the two requesters and the arbiter.
interface adder_seq_arbiter_if #(
    parameter int unsigned OP_W = 9
);
    import adder_seq_arbiter_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [OP_W-1:0]    a0;
    logic [OP_W-1:0]    b0;
    logic               sub0;
    logic [OP_W-1:0]    a1;
    logic [OP_W-1:0]    b1;
    logic               sub1;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] done;
    logic [OP_W-1:0]    result;
    logic               cout;
    logic               busy;

    modport master (
        output req, a0, b0, sub0, a1, b1, sub1,
        input  gnt, done, result, cout, busy
    );

    modport slave (
        input  req, a0, b0, sub0, a1, b1, sub1,
        output gnt, done, result, cout, busy
    );

endinterface

// File: rtl/adder_seq_arbiter_fa3.sv
// Three-bit ripple adder with carry in/out; the shared datapath.
module full_adder_3bit (
    input  logic [2:0] a,
    input  logic [2:0] b,
    input  logic       cin,
    output logic [2:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {3'b000, cin};

endmodule

// File: rtl/adder_seq_arbiter.sv
// Round-robin arbiter sharing one 3-bit adder between two requesters,
// sequencing OP_W-bit add/subtract one chunk per cycle, LSB chunk first.
module adder_seq_arbiter
    import adder_seq_arbiter_pkg::*;
#(
    parameter int unsigned OP_W = 9
) (
    input logic                clk,
    input logic                rst_n,
    adder_seq_arbiter_if.slave bus
);

    localparam int unsigned     N        = OP_W / CHUNK_W;
    localparam int unsigned     IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t state;
    state_t state_nxt;

    logic [OP_W-1:0]         a_q;
    logic [OP_W-1:0]         b_q;
    logic [OP_W-1:0]         sum_q;
    logic                    carry_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    owner_q;
    logic                    last_q;

    logic                    any_req;
    logic                    win;
    logic                    sel_sub;
    logic [OP_W-1:0]         sel_a;
    logic [OP_W-1:0]         sel_b;
    logic [NUM_REQ-1:0]      gnt_nxt;
    logic [NUM_REQ-1:0]      done_nxt;
    logic                    busy_nxt;

    logic [CHUNK_W-1:0]      fa_sum;
    logic                    fa_cout;
    logic [OP_W+CHUNK_W-1:0] sum_cat;

    full_adder_3bit u_fa (
        .a    (a_q[CHUNK_W-1:0]),
        .b    (b_q[CHUNK_W-1:0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Operands shift down each chunk so the adder always sees bit 0; the sum
    // shifts in from the top and is fully aligned after N chunks.
    assign sum_cat = {fa_sum, sum_q};

    assign any_req = |bus.req;

    always_comb begin
        win = bus.req[1];
        if (bus.req[0] && bus.req[1]) begin
            win = ~last_q;
        end
        sel_sub = win ? bus.sub1 : bus.sub0;
        sel_a   = win ? bus.a1 : bus.a0;
        sel_b   = (win ? bus.b1 : bus.b0) ^ {OP_W{sel_sub}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (any_req) state_nxt = RUN;
            RUN:  if (idx_q == LAST_IDX) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_nxt  = '0;
        done_nxt = '0;
        busy_nxt = (state_nxt != IDLE);
        if (state == IDLE && any_req) begin
            gnt_nxt[win] = 1'b1;
        end
        if (state == DONE) begin
            done_nxt[owner_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            bus.gnt    <= '0;
            bus.done   <= '0;
            bus.result <= '0;
            bus.cout   <= 1'b0;
            bus.busy   <= 1'b0;
        end else begin
            bus.gnt  <= gnt_nxt;
            bus.done <= done_nxt;
            bus.busy <= busy_nxt;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        a_q     <= sel_a;
                        b_q     <= sel_b;
                        carry_q <= sel_sub;
                        idx_q   <= '0;
                        owner_q <= win;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> CHUNK_W;
                    b_q     <= b_q >> CHUNK_W;
                    sum_q   <= sum_cat[OP_W+CHUNK_W-1:CHUNK_W];
                    carry_q <= fa_cout;
                    idx_q   <= idx_q + 1'b1;
                end
                DONE: begin
                    bus.result <= sum_q;
                    bus.cout   <= carry_q;
                    last_q     <= owner_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_seq_arbiter.sv
// Directed and randomized checks of adder_seq_arbiter against an
// arithmetic reference model with a round-robin pointer.
module tb_adder_seq_arbiter;

    localparam int unsigned OP_W = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_gnt_cyc = -100;
    bit mdl_last = 1'b1;
    logic [OP_W-1:0] got_res;
    logic            got_cout;

    adder_seq_arbiter_if #(.OP_W(OP_W)) bus ();

    adder_seq_arbiter #(.OP_W(OP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns {carry, result}: sum/difference modulo 2^OP_W; subtract carry = no borrow.
    function automatic logic [OP_W:0] ref_op(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                                             input logic s);
        int unsigned ai;
        int unsigned bi;
        int unsigned m;
        int unsigned r;
        logic        c;
        ai = a;
        bi = b;
        m  = 1 << OP_W;
        if (!s) begin
            r = (ai + bi) % m;
            c = (ai + bi) >= m;
        end else begin
            r = (ai + m - bi) % m;
            c = ai >= bi;
        end
        return {c, r[OP_W-1:0]};
    endfunction

    task automatic rand_ops(input bit which);
        if (which) begin
            bus.a1   = OP_W'($urandom);
            bus.b1   = OP_W'($urandom);
            bus.sub1 = 1'($urandom);
        end else begin
            bus.a0   = OP_W'($urandom);
            bus.b0   = OP_W'($urandom);
            bus.sub0 = 1'($urandom);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt"}, bus.gnt, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_result"}, bus.result, 0);
        check({tag, "_cout"}, bus.cout, 0);
        check({tag, "_busy"}, bus.busy, 0);
    endtask

    task automatic run_op(input logic [1:0] reqv, input logic [1:0] after_req, input bit b2b);
        int n;
        bit w;
        logic [OP_W:0] exp;
        logic [1:0] exp_oh;
        w = (reqv == 2'b11) ? ~mdl_last : reqv[1];
        exp = w ? ref_op(bus.a1, bus.b1, bus.sub1) : ref_op(bus.a0, bus.b0, bus.sub0);
        exp_oh = w ? 2'b10 : 2'b01;
        bus.req = reqv;
        n = 0;
        do begin
            step();
            n++;
        end while (bus.gnt == 2'b00 && n < 20);
        check("gnt", bus.gnt, exp_oh);
        check("busy", bus.busy, 1);
        if (b2b) check("gnt_spacing", cyc - last_gnt_cyc, 5);
        last_gnt_cyc = cyc;
        bus.req = after_req;
        n = 0;
        do begin
            step();
            n++;
        end while (bus.done == 2'b00 && n < 20);
        check("latency", n, 4);
        check("done", bus.done, exp_oh);
        check("result", bus.result, exp[OP_W-1:0]);
        check("cout", bus.cout, exp[OP_W]);
        got_res  = bus.result;
        got_cout = bus.cout;
        mdl_last = w;
    endtask

    initial begin
        int n;
        bus.req  = '0;
        bus.a0   = '0;
        bus.b0   = '0;
        bus.sub0 = 1'b0;
        bus.a1   = '0;
        bus.b1   = '0;
        bus.sub1 = 1'b0;

        // Reset held with random requests
        for (int i = 0; i < 4; i++) begin
            bus.req = 2'($urandom);
            rand_ops(0);
            rand_ops(1);
            step();
            check_idle_outputs("reset");
        end
        bus.req = '0;
        rst_n = 1'b1;
        step();

        // First tie goes to requester 0
        rand_ops(0);
        rand_ops(1);
        run_op(2'b11, 2'b00, 0);

        bus.a0 = 9'd300; bus.b0 = 9'd250; bus.sub0 = 1'b0;
        run_op(2'b01, 2'b00, 0);
        check("add_ovf_res", got_res, 38);
        check("add_ovf_cout", got_cout, 1);

        bus.a1 = 9'd5; bus.b1 = 9'd7; bus.sub1 = 1'b1;
        run_op(2'b10, 2'b00, 0);
        check("sub_borrow_res", got_res, 9'h1FE);
        check("sub_borrow_cout", got_cout, 0);

        bus.a1 = 9'd7; bus.b1 = 9'd5; bus.sub1 = 1'b1;
        run_op(2'b10, 2'b00, 0);
        check("sub_ok_res", got_res, 2);
        check("sub_ok_cout", got_cout, 1);

        bus.a0 = 9'h1FF; bus.b0 = 9'd1; bus.sub0 = 1'b0;
        run_op(2'b01, 2'b00, 0);
        check("carry_chain_res", got_res, 0);
        check("carry_chain_cout", got_cout, 1);

        // Both requesters held: alternating grants, 5 cycles apart
        rand_ops(0);
        rand_ops(1);
        for (int i = 0; i < 4; i++) begin
            run_op(2'b11, (i == 3) ? 2'b00 : 2'b11, i != 0);
            rand_ops(mdl_last);
        end

        // Requester 1 arrives during requester 0's operation
        step();
        rand_ops(0);
        rand_ops(1);
        run_op(2'b01, 2'b10, 0);
        run_op(2'b10, 2'b00, 1);

        // Reset two cycles after a grant abandons the operation
        step();
        rand_ops(0);
        bus.req = 2'b01;
        n = 0;
        do begin
            step();
            n++;
        end while (bus.gnt == 2'b00 && n < 20);
        check("midrst_gnt", bus.gnt, 2'b01);
        bus.req = '0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        for (int i = 0; i < 5; i++) begin
            step();
            check("midrst_hold_done", bus.done, 0);
        end
        rst_n = 1'b1;
        mdl_last = 1'b1;
        step();
        bus.a0 = 9'd100; bus.b0 = 9'd23; bus.sub0 = 1'b0;
        run_op(2'b01, 2'b00, 0);
        check("post_rst_res", got_res, 123);
        check("post_rst_cout", got_cout, 0);

        // Randomized request patterns and operands
        for (int i = 0; i < 12; i++) begin
            rand_ops(0);
            rand_ops(1);
            run_op(2'($urandom_range(1, 3)), 2'b00, 0);
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
